// File: rtl/aes_enc_round_sequencer_if.sv
// Plaintext/key input and ciphertext output handshake bundle of the AES-128 round sequencer.
// Both sides use valid/ready: a transfer happens on a rising edge where valid and ready are both high.
interface aes_enc_round_sequencer_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic [127:0] in_key;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;

    modport master (
        output in_valid, in_data, in_key, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, in_key, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/aes_enc_round_sequencer.sv
// Iterative AES-128 encryption controller: owns the cipher state and key registers and steps one
// block through rounds 0..10 using external SubBytes+ShiftRows, registered MixColumns and key expander.
module aes_enc_round_sequencer (
    input  logic                          clk,
    input  logic                          rst_n,
    aes_enc_round_sequencer_if.slave      bus,
    output logic [127:0]                  sr_in,
    input  logic [127:0]                  sr_out,
    output logic [127:0]                  mc_in,
    input  logic [127:0]                  mc_out,
    output logic [127:0]                  key_q,
    output logic [3:0]                    rnd,
    input  logic [127:0]                  rkey,
    output logic                          busy,
    output logic [15:0]                   blk_cnt,
    output logic [2:0]                    fsm_state
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SUB   = 3'd1,
        MIX   = 3'd2,
        FINAL = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t        state, state_d;
    logic [127:0]  st, st_d;
    logic [127:0]  key_d;
    logic [3:0]    rnd_d;
    logic [15:0]   cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            st      <= '0;
            key_q   <= '0;
            rnd     <= '0;
            blk_cnt <= '0;
        end else begin
            state   <= state_d;
            st      <= st_d;
            key_q   <= key_d;
            rnd     <= rnd_d;
            blk_cnt <= cnt_d;
        end
    end

    always_comb begin
        state_d = state;
        st_d    = st;
        key_d   = key_q;
        rnd_d   = rnd;
        cnt_d   = blk_cnt;
        case (state)
            IDLE: begin
                // Round 0 AddRoundKey uses the raw key, so the expander is not consulted here.
                if (bus.in_valid) begin
                    st_d    = bus.in_data ^ bus.in_key;
                    key_d   = bus.in_key;
                    rnd_d   = 4'd1;
                    state_d = SUB;
                end
            end
            SUB: begin
                state_d = MIX;
            end
            MIX: begin
                st_d = mc_out ^ rkey;
                if (rnd == 4'd9) begin
                    rnd_d   = 4'd10;
                    state_d = FINAL;
                end else begin
                    rnd_d   = rnd + 4'd1;
                    state_d = SUB;
                end
            end
            FINAL: begin
                st_d    = sr_out ^ rkey;
                state_d = DONE;
            end
            DONE: begin
                if (bus.out_ready) begin
                    cnt_d   = blk_cnt + 16'd1;
                    rnd_d   = 4'd0;
                    state_d = IDLE;
                end
            end
            default: begin
                rnd_d   = 4'd0;
                state_d = IDLE;
            end
        endcase
    end

    // Handshake flags decode from the state register alone, never from inputs.
    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.out_data  = st;
    assign busy          = (state != IDLE);
    assign sr_in         = st;
    assign mc_in         = sr_out;
    assign fsm_state     = state;

endmodule

// File: doc/aes_enc_round_sequencer.md
# aes_enc_round_sequencer

Iterative AES-128 encryption controller that owns the 128-bit cipher state register and sequences one block through round 0 and rounds 1–10. Each round uses three external stages:
- a combinational SubBytes+ShiftRows stage,
- the team's registered MixColumns stage (1-cycle latency, same clock, no enable),
- a combinational round-key expander indexed by round number.

It sits between a valid/ready plaintext source and a valid/ready ciphertext sink and processes one block at a time.

## Interface
- No parameters.
- clk  in  1  rising-edge clock for all state.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  plaintext/key offered.
- in_ready  out  1  block can accept; high only in IDLE.
- in_data  in  128  plaintext; byte 0 is at [127:120].
- in_key  in  128  cipher key.
- out_valid  out  1  ciphertext available.
- out_ready  in  1  sink accepts ciphertext.
- out_data  out  128  ciphertext; equals the state register.
- sr_in  out  128  state fed to the SubBytes+ShiftRows stage; equals the state register.
- sr_out  in  128  SubBytes+ShiftRows(sr_in), combinational.
- mc_in  out  128  combinational pass-through of sr_out into the MixColumns stage.
- mc_out  in  128  MixColumns(mc_in) as sampled on the previous clock.
- key_q  out  128  registered cipher key driven to the expander.
- rnd  out  4  current round index, 0..10.
- rkey  in  128  round key for (key_q, rnd), combinational.
- busy  out  1  high in every state except IDLE.
- blk_cnt  out  16  count of completed output handshakes; wraps at 65535→0.

## Operation
States are IDLE, SUB, MIX, FINAL and DONE.

- **IDLE:** in_ready=1.
  - On in_valid&in_ready: state ← in_data ^ in_key (round 0 AddRoundKey is done internally; rkey is not used); key_q ← in_key; rnd ← 1; go to SUB.
  - Otherwise hold.
- **SUB (rnd 1..9):** the state register holds; MixColumns captures sr_out this cycle; go to MIX.
- **MIX (rnd 1..9):** state ← mc_out ^ rkey.
  - If rnd==9: rnd ← 10, go to FINAL.
  - Else: rnd ← rnd+1, go to SUB.
- **FINAL (rnd 10):** state ← sr_out ^ rkey (MixColumns is skipped); go to DONE.
- **DONE:** out_valid=1, rnd stays 10.
  - On out_ready: blk_cnt ← blk_cnt+1 (mod 2^16), rnd ← 0, go to IDLE.
  - Otherwise hold; out_data stays stable.
- in_valid outside IDLE is ignored; in_data and in_key are sampled only on the accept edge.
- Any mc_out value presented in a non-MIX state is ignored.
- The state register changes only on the accept edge, in MIX, and in FINAL.
- No illegal states are reachable. If an unused state encoding appears, go to IDLE on the next edge.

## Timing
- Reset (asynchronous assert, synchronous-safe release) forces these values:
  - state, key_q, rnd, blk_cnt = 0
  - out_valid = 0, busy = 0
  - in_ready = 1 (IDLE)
  - out_data = 0
- Reset mid-operation aborts the block; no output is produced.
- Cycle numbering, with the accept edge at cycle 0:
  - SUB of round r is at cycle 2r−1 and MIX of round r at cycle 2r, for r=1..9.
  - FINAL is at cycle 19.
  - out_valid rises after the edge ending cycle 19, i.e. it is visible in cycle 20.
- Minimum accept-to-accept period is 21 cycles: 20 busy cycles, a DONE cycle with out_ready=1, then IDLE.
  - in_ready is never high in the same cycle as out_valid.
- rnd is registered and stable for the whole cycle. rkey must correspond to the current rnd before the MIX/FINAL edge.
- in_ready, out_valid and busy decode from the state register only; there is no combinational path from any input to them.

## Test plan
- **FIPS-197 C.1 vector.** Drive key 000102030405060708090a0b0c0d0e0f and pt 00112233445566778899aabbccddeeff, with golden SubBytes/ShiftRows, MixColumns and expander models.
  - Required: state = 00102030405060708090a0b0c0d0e0f0 after accept.
  - Required: out_valid in cycle 20 with out_data = 69c4e0d86a7b0430d8cdb78070b4c55a, and blk_cnt = 1.
- **Round trace.** Same vector; sample rnd each cycle.
  - Required: 1,1,2,2,…,9,9,10,10(DONE).
  - Required: after round-1 MIX, state = 89d810e8855ace682d1843d8cb128fe4.
- **Backpressure.** Hold out_ready=0 for 7 cycles in DONE while in_valid=1 with a different pt.
  - Required: out_data stable, in_ready=0, second pt not accepted.
  - Required: the second block is accepted one cycle after the out handshake.
- **Reset mid-operation.** Pulse rst_n low asynchronously (between edges) at cycle 11 of a block.
  - Required: in_ready=1, busy=0, rnd=0, out_valid=0 immediately.
  - Required: a fresh FIPS vector afterwards yields the correct ciphertext.
- **Back-to-back and counter.** Issue 3 blocks with in_valid and out_ready tied high.
  - Required: accepts at cycles 0, 21 and 42.
  - Required: blk_cnt = 3.
- **Counter wrap.** Force blk_cnt to 65535, then complete one block.
  - Required: blk_cnt = 0.
